serial_mult_hs: RTL and testbench
=================================

# serial_mult_hs

Parametrised shift-and-add multiplier: the next generation of the team's 4-bit serial multiplier. It generalises operand width and adds a signed mode, optional early termination, and a valid/ready handshake with output backpressure and abort. It sits between a ready/valid operand source and a result consumer in datapaths where area matters more than throughput; one operation is in flight at a time.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH
- EARLY_EXIT, 1, 1 = leave RUN as soon as the remaining multiplier bits are all zero; 0 = always run WIDTH cycles
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  multiplier, sampled on accept
- b  input  WIDTH  multiplicand, sampled on accept
- signed_mode  input  1  1 = a, b and product are two's complement; sampled on accept
- abort  input  1  synchronous cancel of the current operation
- out_valid  output  1  result valid; held until consumed
- out_ready  input  1  consumer accepts result
- result  output  2*WIDTH  product
- busy  output  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE. Reset (rst_n low, async): state IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal registers 0.
- IDLE: in_ready=1. On in_valid&&in_ready: load mag_a=|a|, mag_b=|b| (raw values when signed_mode=0), neg=signed_mode&&(a[MSB]^b[MSB]), acc=0, count=WIDTH; go to RUN.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held in WIDTH bits unsigned; the datapath never overflows.
- RUN, each cycle: sum = acc + (mag_a[0] ? mag_b zero-extended and shifted to the current bit weight : 0) at 2*WIDTH bits; mag_a >>= 1; count -= 1.
- RUN exit when count==1, or when EARLY_EXIT=1 and (mag_a>>1)==0. On exit: result <= neg ? -sum : sum (2*WIDTH two's complement), out_valid <= 1, go to DONE.
- DONE: out_valid=1, result stable. On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- abort=1 in RUN or DONE: go to IDLE next edge, out_valid <= 0, result keeps its previous value. abort has priority over RUN exit and over out_ready. abort is ignored in IDLE; in IDLE it does not block accept.
- A product of zero, including a=0 or b=0, is a normal result. The value of neg does not change it, because -0 = 0.

## Timing
- Accept edge = edge 0. k RUN cycles follow. out_valid rises after edge k. Latency is k cycles.
- k = WIDTH when EARLY_EXIT=0.
- k = max(1, index of the highest set bit of |a| + 1) when EARLY_EXIT=1. k=1 when |a|=0.
- in_ready is low from edge 0 until the edge after the result is consumed, so the earliest next accept is one cycle after the handshake. in_ready and out_valid are never high together.
- Throughput: one operation per k+2 cycles when out_ready is held high.
- busy = (state != IDLE). All outputs are registered or are decodes of state only; none depend combinationally on inputs.
- Reset asserted mid-operation: the operation is lost. Outputs take their reset values immediately, with no clock edge needed.

## Test plan
- WIDTH=4, EARLY_EXIT=0, unsigned, a=15, b=15, out_ready=1 -> result=8'hE1 (225), out_valid high exactly 4 cycles after accept; a=3, b=5 -> 8'h0F, also 4 cycles.
- WIDTH=4, EARLY_EXIT=1, unsigned: a=3, b=5 -> 8'h0F after 2 cycles; a=0, b=9 -> 8'h00 after 1 cycle; a=8, b=2 -> 8'h10 after 4 cycles.
- WIDTH=4, signed: a=-3 (4'hD), b=5 -> 8'hF1 (-15); a=-8, b=-8 -> 8'h40 (64); a=-8, b=7 -> 8'hC8 (-56); a=0, b=-1 -> 8'h00.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_ready=0, new in_valid not accepted; raise out_ready -> out_valid falls next edge, in_ready=1 the cycle after.
- Abort: pulse abort on the 2nd RUN cycle of a=15, b=15 -> IDLE next edge, out_valid never rises, result unchanged; then accept a=2, b=3 -> 8'h06. Abort in DONE concurrent with out_ready -> out_valid drops, no double consumption.
- Reset: drop rst_n mid-RUN between clock edges -> in_ready=1, out_valid=0, busy=0, result=0 immediately; after release, a=6, b=7 -> 8'h2A.

Source files
------------

// File: rtl/serial_mult_hs_if.sv
// Handshake bundle for serial_mult_hs: operand channel, result channel, abort and status.
// The master side (operand source / result consumer) drives operands; the slave is the multiplier.
interface serial_mult_hs_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               busy;

  modport master (
    output in_valid, a, b, signed_mode, abort, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, abort, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/serial_mult_hs.sv
// Shift-and-add multiplier with signed mode, optional early exit and ready/valid handshake.
// Works on operand magnitudes and applies the sign once, when the result is written.
module serial_mult_hs #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_mult_hs_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), still fitting WIDTH bits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = ~v + WIDTH'(1);
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic negate);
    if (negate) begin
      apply_sign = ~v + PW'(1);
    end else begin
      apply_sign = v;
    end
  endfunction

  logic [1:0]       state_r;
  logic [WIDTH-1:0] mag_a_r;
  logic [PW-1:0]    mag_b_sh_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    count_r;
  logic             neg_r;
  logic [PW-1:0]    result_r;
  logic             out_valid_r;

  logic [PW-1:0]    addend_s;
  logic [PW-1:0]    sum_s;
  logic             exit_s;
  logic             accept_s;

  // Partial-product sum, RUN exit decision and operand accept.
  always_comb begin
    addend_s = '0;
    sum_s    = '0;
    exit_s   = 1'b0;
    accept_s = 1'b0;
    if (mag_a_r[0]) begin
      addend_s = mag_b_sh_r;
    end else begin
      addend_s = '0;
    end
    sum_s = acc_r + addend_s;
    if (count_r == CW'(1)) begin
      exit_s = 1'b1;
    end else if (EARLY_EXIT && ((mag_a_r >> 1) == '0)) begin
      exit_s = 1'b1;
    end else begin
      exit_s = 1'b0;
    end
    if (state_r == ST_IDLE) begin
      accept_s = bus.in_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control FSM; abort outranks both RUN exit and result consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_r <= ST_RUN;
          else          state_r <= ST_IDLE;
        end
        ST_RUN: begin
          if (bus.abort)   state_r <= ST_IDLE;
          else if (exit_s) state_r <= ST_DONE;
          else             state_r <= ST_RUN;
        end
        ST_DONE: begin
          if (bus.abort || bus.out_ready) state_r <= ST_IDLE;
          else                            state_r <= ST_DONE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Datapath: load magnitudes on accept, then one shift-and-add step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_r    <= '0;
      mag_b_sh_r <= '0;
      acc_r      <= '0;
      count_r    <= '0;
      neg_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mag_a_r    <= magnitude(bus.a, bus.signed_mode);
            mag_b_sh_r <= {{WIDTH{1'b0}}, magnitude(bus.b, bus.signed_mode)};
            acc_r      <= '0;
            count_r    <= CW'(WIDTH);
            neg_r      <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end else begin
            mag_a_r    <= mag_a_r;
            mag_b_sh_r <= mag_b_sh_r;
            acc_r      <= acc_r;
            count_r    <= count_r;
            neg_r      <= neg_r;
          end
        end
        ST_RUN: begin
          mag_a_r    <= mag_a_r >> 1;
          mag_b_sh_r <= mag_b_sh_r << 1;
          acc_r      <= sum_s;
          count_r    <= count_r - CW'(1);
          neg_r      <= neg_r;
        end
        default: begin
          mag_a_r    <= mag_a_r;
          mag_b_sh_r <= mag_b_sh_r;
          acc_r      <= acc_r;
          count_r    <= count_r;
          neg_r      <= neg_r;
        end
      endcase
    end
  end

  // Result register and out_valid; an aborted operation leaves the previous result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!bus.abort && exit_s) begin
            result_r    <= apply_sign(sum_s, neg_r);
            out_valid_r <= 1'b1;
          end else begin
            result_r    <= result_r;
            out_valid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          result_r <= result_r;
          if (bus.abort || bus.out_ready) out_valid_r <= 1'b0;
          else                            out_valid_r <= 1'b1;
        end
        default: begin
          result_r    <= result_r;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_serial_mult_hs.sv
// Bench for serial_mult_hs at WIDTH=4: one instance without and one with early exit,
// selected by sel; vector table plus handshake, abort and reset sequences.
module tb_serial_mult_hs;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic         in_valid;
  logic         signed_mode;
  logic         abort;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  int errors = 0;
  int checks = 0;

  serial_mult_hs_if #(.WIDTH(W)) if0 ();
  serial_mult_hs_if #(.WIDTH(W)) if1 ();

  assign if0.in_valid    = in_valid & ~sel;
  assign if1.in_valid    = in_valid & sel;
  assign if0.abort       = abort & ~sel;
  assign if1.abort       = abort & sel;
  assign if0.a           = a;
  assign if1.a           = a;
  assign if0.b           = b;
  assign if1.b           = b;
  assign if0.signed_mode = signed_mode;
  assign if1.signed_mode = signed_mode;
  assign if0.out_ready   = out_ready;
  assign if1.out_ready   = out_ready;

  serial_mult_hs #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  serial_mult_hs #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic           in_ready_m, out_valid_m, busy_m;
  logic [2*W-1:0] result_m;
  assign in_ready_m  = sel ? if1.in_ready  : if0.in_ready;
  assign out_valid_m = sel ? if1.out_valid : if0.out_valid;
  assign busy_m      = sel ? if1.busy      : if0.busy;
  assign result_m    = sel ? if1.result    : if0.result;

  always #5 clk = ~clk;

  typedef struct {
    logic           sel;
    logic           sm;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    int             lat;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called right after a negedge; returns right after the negedge following the accept edge.
  task automatic start_op(input logic s, input logic sm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input string name);
    sel = s; signed_mode = sm; a = aa; b = bb; in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, {31'd0, in_ready_m}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_lat"}, lat, e.lat);
      check({name, "_res"}, {24'd0, result_m}, {24'd0, e.res});
      check({name, "_ovld_inrdy"}, {30'd0, out_valid_m, in_ready_m}, 32'd2);
    end
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_consumed"}, {30'd0, out_valid_m, in_ready_m}, 32'd1);
    end
  endtask

  task automatic run_op(input logic s, input logic sm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [2*W-1:0] er, input int el, input string name);
    exp_t e;
    start_op(s, sm, aa, bb, name);
    e.res = er;
    e.lat = el;
    exp_q.push_back(e);
    finish_op(name);
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 4'hF, 8'hE1, 4};
    vecs[1]  = '{1'b0, 1'b0, 4'h3, 4'h5, 8'h0F, 4};
    vecs[2]  = '{1'b1, 1'b0, 4'h3, 4'h5, 8'h0F, 2};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h9, 8'h00, 1};
    vecs[4]  = '{1'b1, 1'b0, 4'h8, 4'h2, 8'h10, 4};
    vecs[5]  = '{1'b0, 1'b1, 4'hD, 4'h5, 8'hF1, 4};
    vecs[6]  = '{1'b0, 1'b1, 4'h8, 4'h8, 8'h40, 4};
    vecs[7]  = '{1'b0, 1'b1, 4'h8, 4'h7, 8'hC8, 4};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'hF, 8'h00, 4};
    vecs[9]  = '{1'b1, 1'b1, 4'hD, 4'h5, 8'hF1, 2};
    vecs[10] = '{1'b1, 1'b1, 4'h8, 4'h7, 8'hC8, 4};
    vecs[11] = '{1'b1, 1'b1, 4'h0, 4'hF, 8'h00, 1};
    vecs[12] = '{1'b1, 1'b0, 4'h1, 4'hF, 8'h0F, 1};
    vecs[13] = '{1'b0, 1'b1, 4'hF, 4'hF, 8'h01, 4};
    vecs[14] = '{1'b1, 1'b1, 4'h7, 4'h8, 8'hC8, 3};

    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; signed_mode = 1'b0;
    abort = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #2;
    check("reset_dut0", {20'd0, if0.in_ready, if0.out_valid, if0.busy, if0.result, 1'b0},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    check("reset_dut1", {20'd0, if1.in_ready, if1.out_valid, if1.busy, if1.result, 1'b0},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].sel, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 10 cycles while a competing in_valid is ignored.
    out_ready = 1'b0;
    run_op(1'b0, 1'b0, 4'h3, 4'h5, 8'h0F, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 4'h1; b = 4'h1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {22'd0, out_valid_m, in_ready_m, busy_m, result_m},
            {22'd0, 1'b1, 1'b0, 1'b1, 8'h0F});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", {29'd0, out_valid_m, in_ready_m, busy_m}, {29'd0, 3'b010});

    // Abort on the second RUN cycle.
    start_op(1'b0, 1'b0, 4'hF, 4'hF, "abort_run");
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_run_idle", {21'd0, out_valid_m, in_ready_m, busy_m, result_m},
          {21'd0, 3'b010, 8'h0F});
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | out_valid_m;
    end
    check("abort_run_no_ovld", {31'd0, seen}, 32'd0);
    run_op(1'b0, 1'b0, 4'h2, 4'h3, 8'h06, 4, "after_abort");

    // Abort in DONE together with out_ready.
    out_ready = 1'b0;
    run_op(1'b0, 1'b0, 4'h1, 4'h1, 8'h01, 4, "abort_done");
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_idle", {21'd0, out_valid_m, in_ready_m, busy_m, result_m},
          {21'd0, 3'b010, 8'h01});
    run_op(1'b0, 1'b0, 4'h2, 4'h7, 8'h0E, 4, "after_abort_done");

    // Asynchronous reset between clock edges mid-RUN.
    start_op(1'b0, 1'b0, 4'hF, 4'hF, "rst_run");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {21'd0, out_valid_m, in_ready_m, busy_m, result_m}, {21'd0, 3'b010, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 1'b0, 4'h6, 4'h7, 8'h2A, 4, "after_rst");

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
